// File: rtl/alu_pkg.sv
// Shared definitions for the rotate/ALU blocks: FSM state type, flag bit positions, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit positions inside the 4-bit {Neg, Zero, Carry, oVerflow} flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AMT_W = 4;

endpackage

// File: rtl/rol_flags.sv
// Combinational flag generator for a rotate result: {Neg, Zero, Carry, oVerflow}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to capture the flags.
module rol_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    input  logic             rotated,
    output logic [3:0]       flag
);

    // Carry is the last bit that wrapped from the top to bit 0, so it only
    // exists when at least one single-bit rotate step happened.
    always_comb begin
        flag         = 4'b0000;
        flag[FLAG_N] = result[WIDTH-1];
        flag[FLAG_Z] = (result == '0);
        flag[FLAG_C] = rotated & result[0];
        flag[FLAG_V] = 1'b0;
    end

endmodule

// File: rtl/rol_seq.sv
// Sequential left-rotate: one single-bit rotate per cycle, N steps, then a one-cycle done pulse.
// Latency: done in cycle t0+N+1 after the accepting edge t0 (N=0 -> t0+1).
// Backpressure: start is taken only in IDLE; requests while busy or in DONE are dropped. Flags need ROL_SEQ_FLAGS_EN.
module rol_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [AMT_W-1:0] N,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flag
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_rot;
    logic [WIDTH-1:0] result_nxt;
    logic [AMT_W-1:0] cnt;
    logic             accept;
    logic             load_res;

    assign accept   = (state == ST_IDLE) && start;
    assign work_rot = {work[WIDTH-2:0], work[WIDTH-1]};

    // Result is captured on the edge that enters DONE so it is already valid
    // while done is high: the raw operand for N=0, else the final rotate step.
    assign result_nxt = (state == ST_IDLE) ? in1 : work_rot;
    assign load_res   = (state_nxt == ST_DONE) && (state != ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (N != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt == AMT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: busy covers SHIFT and DONE, done is the DONE cycle only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Working register and down-counter: load on accept, step once per SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            work <= in1;
            cnt  <= N;
        end else if (state == ST_SHIFT) begin
            work <= work_rot;
            cnt  <= cnt - AMT_W'(1);
        end
    end

    // Result holds between operations and clears only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result <= '0;
        end else if (load_res) begin
            Result <= result_nxt;
        end
    end

`ifdef ROL_SEQ_FLAGS_EN
    logic [3:0] flag_nxt;

    // Entering DONE from SHIFT means at least one bit wrapped around
    rol_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .result  (result_nxt),
        .rotated (state == ST_SHIFT),
        .flag    (flag_nxt)
    );

    // Flags are captured alongside Result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Flag <= 4'b0000;
        end else if (load_res) begin
            Flag <= flag_nxt;
        end
    end
`else
    assign Flag = 4'b0000;
`endif

endmodule

// File: tb/tb_rol_seq.sv
// Directed bench for rol_seq: latency, result, flags, ignored starts, reset abort.
// Expected flags collapse to 0000 when built without ROL_SEQ_FLAGS_EN.
module tb_rol_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic [3:0]  N;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [3:0]  Flag;

    int n_chk = 0;
    int n_bad = 0;

    rol_seq #(
        .WIDTH (32),
        .AMT_W (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in1    (in1),
        .N      (N),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Flag   (Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef ROL_SEQ_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    // One operation: start sampled at edge t0; cycle t0+k is the period after edge t0+k-1.
    // poke_at > 0 drives a second start (in1=1, N=1) during that cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [3:0] n,
                          input int poke_at, input logic [31:0] exp_res,
                          input logic [3:0] exp_flg, input int exp_lat);
        int   lat;
        logic extra;
        @(negedge clk);
        start = 1'b1;
        in1   = a;
        N     = n;
        @(negedge clk);
        start = 1'b0;
        in1   = '0;
        N     = '0;
        lat   = 1;
        while (!done && lat < 40) begin
            chk({tag, ":busy"}, 32'(busy), 32'd1);
            if (lat == poke_at) begin
                start = 1'b1;
                in1   = 32'd1;
                N     = 4'd1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":busy_done"}, 32'(busy), 32'd1);
        chk({tag, ":res"}, Result, exp_res);
        chk({tag, ":flag"}, 32'(Flag), 32'(fx(exp_flg)));
        if (lat == poke_at) begin
            start = 1'b1;
            in1   = 32'd1;
            N     = 4'd1;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, ":pulse"}, 32'(done), 32'd0);
        chk({tag, ":idle"}, 32'(busy), 32'd0);
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            extra |= done | busy;
        end
        chk({tag, ":no_extra"}, 32'(extra), 32'd0);
        chk({tag, ":hold"}, Result, exp_res);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        N     = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", Result, 32'd0);
        chk("rst_flag", 32'(Flag), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("rot2_3",   32'd2,          4'd3,  0, 32'd16,         4'b0000, 4);
        run_op("wrap1",    32'h8000_0001,  4'd1,  0, 32'h0000_0003,  4'b0010, 2);
        run_op("n0",       32'd6,          4'd0,  0, 32'd6,          4'b0000, 1);
        run_op("zero",     32'd0,          4'd5,  0, 32'd0,          4'b0100, 6);
        run_op("busy_ign", 32'd5,          4'd9,  3, 32'h0000_0A00,  4'b0000, 10);
        run_op("done_ign", 32'd3,          4'd0,  1, 32'd3,          4'b0000, 1);
        run_op("max_amt",  32'h0003_0000,  4'd15, 0, 32'h8000_0001,  4'b1010, 16);

        // Reset in the middle of an operation: immediate clear, no done afterwards
        @(negedge clk);
        start = 1'b1;
        in1   = 32'd10;
        N     = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res", Result, 32'd0);
        chk("abort_flag", 32'(Flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen |= done | busy;
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        run_op("after_rst", 32'd10, 4'd10, 0, 32'h0000_2800, 4'b0000, 11);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/rol_seq.md
ROL_SEQ -- requirements
Module: rol_seq

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits.
REQ-002 Parameter AMT_W, 4, rotate-amount width; max amount 2^AMT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 in1  input  WIDTH  operand, latched on accepted start.
REQ-007 N  input  AMT_W  left-rotate amount, latched on accepted start.
REQ-008 busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-009 done  output  1  one-cycle pulse; Result/Flag valid from this cycle.
REQ-010 Result  output  WIDTH  rotated operand.
REQ-011 Flag  output  4  {Neg, Zero, Carry, oVerflow}.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; encoding is free.
REQ-013 IDLE: start=1 at edge t0 latches in1 into a working register and N into a down-counter; the next state is SHIFT if N!=0, else DONE.
REQ-014 SHIFT: each cycle rotates the working register left by 1 (bit WIDTH-1 to bit 0) and decrements the counter; the cycle that rotates with counter==1 moves to DONE.
REQ-015 Latency: done high in cycle t0+N+1 (N=0 -> t0+1); exactly one done pulse per accepted start.
REQ-016 DONE: lasts one cycle; Result and Flag update in that cycle; return to IDLE.
REQ-017 Result/Flag hold their value until the next DONE or reset.
REQ-018 start while busy=1 SHALL be ignored; no queuing.
REQ-019 start in the DONE cycle is ignored; a new start is accepted in the following IDLE cycle at the earliest.
REQ-020 Flag.Neg = Result[WIDTH-1]; Flag.Zero = (Result==0); Flag.Carry = last bit rotated out (= Result[0] when N!=0, 0 when N=0); Flag.oVerflow = 0.
REQ-021 Amounts >= WIDTH are not possible with the defaults; if parameterised so, rotation is modulo WIDTH by construction (N single-bit steps).

Reset
REQ-022 rst_n low SHALL force IDLE, busy=0, done=0, Result=0, Flag=0, counter=0 immediately.
REQ-023 Reset mid-operation aborts it; no done is issued for that operation.

Configuration
REQ-024 Macro ROL_SEQ_FLAGS_EN: defined -> Flag computed per REQ-020; undefined -> Flag tied to 4'b0000 and the flag logic is absent; Result and timing are unaffected.

Structure
REQ-025 Shared package alu_pkg holds the FSM state typedef, the flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and default WIDTH/AMT_W.
REQ-026 One sub-module, rol_flags (combinational flag generator), instantiated only under ROL_SEQ_FLAGS_EN; the FSM and datapath are in rol_seq.

Verification
REQ-027 in1=2, N=3, start at t0 -> busy cycles t0+1..t0+4, done at t0+4, Result=16, Flag=0000.
REQ-028 in1=0x80000001, N=1 -> done at t0+2, Result=0x00000003, Flag=0010.
REQ-029 in1=6, N=0 -> done at t0+1, Result=6, Flag=0000; in1=0, N=5 -> Result=0, Flag=0100.
REQ-030 in1=5, N=9, second start (in1=1, N=1) asserted at t0+3 -> ignored; single done at t0+10, Result=0x00000A00.
REQ-031 in1=10, N=10, rst_n pulsed low at t0+4 -> outputs 0 at once, IDLE, no done; new start then runs normally (Result=0x00002800).
REQ-032 Build without ROL_SEQ_FLAGS_EN, rerun REQ-028 -> Result identical, Flag=0000.
